seq_scan_ctrl: RTL and testbench

Controller that feeds a serial pattern detector from a parallel word stream. It accepts WORD_W-bit words over a valid/ready handshake and serialises them MSB-first, one bit per clock. It runs a registered, Moore-style match on the programmable PATTERN (default 10011) and counts matches, with overlap selectable at run time. The block sits between a word-oriented producer and status/interrupt logic, replacing bit-by-bit din driving.

---
 rtl/seq_scan_ctrl_if.sv | 13 +
 rtl/seq_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seq_scan_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seq_scan_ctrl_if.sv
// Word-stream handshake into the serial scan controller.
// A word transfers on a rising edge where in_valid and in_ready are both high;
// the producer holds in_valid and in_data stable until that edge.
interface seq_scan_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serialises handshaked words MSB-first into a registered Moore pattern
// detector with a saturating match counter and run-time overlap selection.
module seq_scan_ctrl #(
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10011,
  parameter int               CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_scan_ctrl_if.slave     in_bus,
  input  logic               overlap_en,
  input  logic               clear,
  output logic               busy,
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               state_dbg
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FW = $clog2(PAT_W + 1);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t            state, state_nx;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [PAT_W-1:0]  history, hist_nx;
  logic [FW-1:0]     fill, fill_nx;
  logic              load, consume, ready_c, match, cur_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // The last-bit cycle of SHIFT accepts the next word so back-to-back words stream without a gap.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    consume  = 1'b0;
    ready_c  = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (in_bus.in_valid) begin
          load     = 1'b1;
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        consume = 1'b1;
        if (bit_cnt == '0) begin
          ready_c = 1'b1;
          if (in_bus.in_valid) load = 1'b1;
          else                 state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign in_bus.in_ready = ready_c & reset;
  assign state_dbg       = state;

  assign cur_bit = shreg[WORD_W-1];
  assign hist_nx = {history[PAT_W-2:0], cur_bit};
  assign fill_nx = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
  assign match   = consume && (hist_nx == PATTERN) && (fill_nx == FW'(PAT_W));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      history      <= '0;
      fill         <= '0;
      seq_detected <= 1'b0;
      match_count  <= '0;
      count_sat    <= 1'b0;
    end else begin
      if (load) begin
        shreg   <= in_bus.in_data;
        bit_cnt <= CW'(WORD_W - 1);
      end else if (consume) begin
        shreg   <= {shreg[WORD_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - CW'(1);
      end
      // clear outranks a match on the same edge and drops the bit consumed there.
      if (clear) begin
        history      <= '0;
        fill         <= '0;
        seq_detected <= 1'b0;
        match_count  <= '0;
        count_sat    <= 1'b0;
      end else begin
        seq_detected <= match;
        if (consume) begin
          if (match && !overlap_en) begin
            history <= '0;
            fill    <= '0;
          end else begin
            history <= hist_nx;
            fill    <= fill_nx;
          end
        end
        if (match) begin
          if (&match_count) count_sat   <= 1'b1;
          else              match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: expected pulses (cycle, count, sticky)
// are queued by the driver and consumed by an independent monitor.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 2;
  localparam int EW     = 19;  // {cycle[15:0], count[1:0], sat}

  logic             clk = 1'b0;
  logic             reset;
  logic             overlap_en;
  logic             clear;
  logic             busy;
  logic             seq_detected;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             state_dbg;
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [EW-1:0]    exp_q[$];

  seq_scan_ctrl_if #(.WORD_W(WORD_W)) bus ();

  seq_scan_ctrl #(
    .WORD_W(WORD_W), .PAT_W(5), .PATTERN(5'b10011), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_bus(bus.slave), .overlap_en(overlap_en),
    .clear(clear), .busy(busy), .seq_detected(seq_detected),
    .match_count(match_count), .count_sat(count_sat), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every seq_detected pulse must match the head of the queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0 && int'(exp_q[0][18:3]) == cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (seq_detected !== 1'b1 || match_count !== e[2:1] || count_sat !== e[0]) begin
        n_bad++;
        $display("FAIL pulse @cyc %0d: got det=%0b cnt=%0d sat=%0b, want det=1 cnt=%0d sat=%0b",
                 cyc, seq_detected, match_count, count_sat, e[2:1], e[0]);
      end
    end else if (seq_detected !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected pulse @cyc %0d: got det=%0b, want det=0", cyc, seq_detected);
    end
  end

  // Driver: call at a negedge with the DUT idle. Word i is accepted at edge a[i];
  // stream bit j is consumed at edge a[j/8]+1+j%8, so its pulse is seen at that cycle.
  task automatic send_words(input logic [7:0] w [3], input int n, input int gap,
                            input bit ov, input int hit [5], input int cnt [5],
                            input int sat [5], input int nh, input int clr_bit,
                            input bit chk_hs);
    int a [3];
    int last, c, e;
    logic vld;
    logic [7:0] dat;
    a[0] = cyc + 1;
    for (int i = 1; i < n; i++) a[i] = a[i-1] + 8 + gap;
    for (int k = 0; k < nh; k++) begin
      e = a[hit[k] / 8] + 1 + (hit[k] % 8);
      exp_q.push_back({e[15:0], cnt[k][1:0], sat[k][0]});
    end
    overlap_en = ov;
    last = a[n-1] + 8;
    while (cyc <= last) begin
      c = cyc;
      if (chk_hs && c >= a[0] && c < a[0] + 8 * n) begin
        chk("busy_in_shift", {31'd0, busy}, 32'd1);
        chk("in_ready_in_shift", {31'd0, bus.in_ready}, {31'd0, ((c - a[0]) % 8) == 7});
      end
      vld = 1'b0;
      dat = bus.in_data;
      for (int i = n - 1; i >= 0; i--) if (c <= a[i] - 1) dat = w[i];
      if (gap == 0) vld = (c >= a[0] - 1) && (c <= a[n-1] - 1);
      else for (int i = 0; i < n; i++) if (c == a[i] - 1) vld = 1'b1;
      clear = (clr_bit >= 0) && (c == a[clr_bit / 8] + (clr_bit % 8));
      bus.in_valid = vld;
      bus.in_data  = dat;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    clear = 1'b0;
    chk("busy_after_stream", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("count_after_clear", {30'd0, match_count}, 32'd0);
    chk("sat_after_clear", {31'd0, count_sat}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    overlap_en = 1'b0;
    clear = 1'b0;

    // reset / idle
    repeat (2) begin
      @(negedge clk);
      chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_count", {30'd0, match_count}, 32'd0);
      chk("idle_state", {31'd0, state_dbg}, 32'd0);
    end

    // overlap across a word boundary: 10011001 10011100
    send_words('{8'h99, 8'h9C, 8'h00}, 2, 0, 1'b1, '{4, 8, 12, 0, 0},
               '{1, 2, 3, 0, 0}, '{0, 0, 0, 0, 0}, 3, -1, 1'b1);
    chk("overlap_count", {30'd0, match_count}, 32'd3);
    chk("overlap_sat", {31'd0, count_sat}, 32'd0);
    do_clear();

    // non-overlap, same stream
    send_words('{8'h99, 8'h9C, 8'h00}, 2, 0, 1'b0, '{4, 12, 0, 0, 0},
               '{1, 2, 0, 0, 0}, '{0, 0, 0, 0, 0}, 2, -1, 1'b0);
    chk("nonoverlap_count", {30'd0, match_count}, 32'd2);
    do_clear();

    // idle gap between words: 00000100 _ _ _ 11000000
    send_words('{8'h04, 8'hC0, 8'h00}, 2, 3, 1'b1, '{9, 0, 0, 0, 0},
               '{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 1, -1, 1'b0);
    chk("gap_count", {30'd0, match_count}, 32'd1);
    do_clear();

    // saturation, then clear on the 5th match edge (bit 20)
    send_words('{8'h99, 8'h99, 8'h99}, 3, 0, 1'b1, '{4, 8, 12, 16, 0},
               '{1, 2, 3, 3, 0}, '{0, 0, 0, 1, 0}, 4, 20, 1'b0);
    chk("sat_count_after_clear", {30'd0, match_count}, 32'd0);
    chk("sat_flag_after_clear", {31'd0, count_sat}, 32'd0);

    // reset while bit 3 of 10011000 is pending
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h98;
    begin
      int a0;
      a0 = cyc + 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (cyc < a0 + 3) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_count", {30'd0, match_count}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_words('{8'h98, 8'h00, 8'h00}, 1, 0, 1'b1, '{4, 0, 0, 0, 0},
               '{1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 1, -1, 1'b0);
    chk("resend_count", {30'd0, match_count}, 32'd1);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
